opl2_host_if: RTL and testbench
===============================

# opl2_host_if

Host-side register-write front end for the OPL2 core. Decodes the two-port CPU bus interface (address port at A0=0, data port at A0=1) into single-cycle `opl2_reg_wr_t` writes consumed by the register file. Emulates the YM3812 post-write wait time on a `busy` output and returns the status byte on reads. Sits directly upstream of the register file, in the `clk` domain.

## Interface
- `ADDR_WAIT_CYCLES`, default 235: busy length after an address-port write (12 OPL2 master clocks at 70 MHz).
- `DATA_WAIT_CYCLES`, default 1643: busy length after a data-port write (84 OPL2 master clocks at 70 MHz).
- `clk` input, 1 bit: master clock. One clock.
- `reset` input, 1 bit: synchronous, active-high.
- `cs_n` input, 1 bit: chip select, active low. Already synchronous to `clk`.
- `wr_n` input, 1 bit: write strobe, active low. Already synchronous to `clk`.
- `rd_n` input, 1 bit: read strobe, active low.
- `address` input, 1 bit: A0. 0 selects the address port, 1 selects the data port.
- `din` input, 8 bits: write data.
- `dout` output, 8 bits: registered read data.
- `irq` input, 1 bit: timer IRQ flag from the timers block.
- `ft1` input, 1 bit: timer 1 overflow flag.
- `ft2` input, 1 bit: timer 2 overflow flag.
- `opl2_reg_wr` output, `opl2_reg_wr_t` (17 bits: valid, address[7:0], data[7:0]): register-write pulse.
- `busy` output, 1 bit: high while the emulated wait time is running.

## Operation
- **Write event.** Asserted in the cycle where `cs_n==0`, `wr_n==0`, and the registered previous `wr_n` (`wr_n_q`) is 1. One event per falling edge; holding `wr_n` low produces no further events.
- **Address-port event (`address==0`).**
  - `addr_q <= din`.
  - No register write is issued.
  - The wait counter loads `ADDR_WAIT_CYCLES`.
- **Data-port event (`address==1`).**
  - If `addr_q < 'hF6` (NUM_REG_PER_BANK): `opl2_reg_wr <= {1, addr_q, din}` for exactly one cycle.
  - Otherwise the write is dropped and valid stays 0.
  - In both cases the wait counter loads `DATA_WAIT_CYCLES`.
  - `addr_q` is unchanged, so repeated data writes go to the same register.
- **Wait counter.**
  - Width is `$clog2(DATA_WAIT_CYCLES+1)`.
  - Decrements by 1 per cycle while nonzero.
  - `busy = (count != 0)`, registered.
  - A write event while busy is still accepted and reloads the counter; it does not add to the remaining count. `busy` is advisory only: nothing is blocked.
- **Read.**
  - Each cycle, `dout <= (cs_n==0 && rd_n==0) ? (address==0 ? {irq, ft1, ft2, 5'b00110} : 8'hFF) : dout`.
  - `dout` holds its last value when not reading.
- **Simultaneous read and write strobes.** The write is processed and `dout` still updates per the read rule.
- `opl2_reg_wr.valid` is a pulse. address/data fields hold their last value when valid is 0.
- **Reset values.**
  - `addr_q = 0`, `wr_n_q = 0`, `count = 0`.
  - `busy = 0`, `dout = 8'h00`.
  - `opl2_reg_wr = '0`.
  - Because `wr_n_q` resets to 0, a `wr_n` held low through reset release produces no event until `wr_n` rises and falls again.
- **Reset mid-operation.** The counter clears, `busy` drops on the next cycle, and `addr_q` returns to 0.

## Timing
- Write event sampled at cycle N. `opl2_reg_wr.valid` is high in cycle N+1 only.
- `busy` is high from cycle N+1 through cycle N+W, and low at N+W+1, where W is the loaded wait value.
- Reload at cycle M while busy: `busy` is high continuously, then low at M+W+1.
- Read: `dout` reflects the inputs of cycle N in cycle N+1. Status is sampled, not latched across the strobe.
- Back-to-back events need at least 2 cycles (`wr_n` must be seen high for one sampled cycle between them). Minimum event spacing is 2 cycles and every qualifying event is honoured.

## Test plan
- **Basic write.** After reset, write A0=0 `din=8'h20`, then A0=1 `din=8'h01` → exactly one valid pulse with `{addr=8'h20, data=8'h01}`, one cycle after the data event.
- **Busy length.** Data write at cycle N with defaults → `busy` high for exactly 1643 cycles (N+1 through N+1643). Address write → high for exactly 235 cycles.
- **Out-of-range address.** Write address `8'hF6`, then data `8'h55` → no valid pulse, but `busy` runs 1643 cycles. Then address `8'hF5` + data → pulse issued.
- **Reload and strobe handling.**
  - Data write 100 cycles into an address wait → counter reloads; `busy` ends 1643 cycles after the second event.
  - `wr_n` held low for 50 cycles → exactly one pulse.
- **Status read.** `irq=1`, `ft1=1`, `ft2=0`, A0=0 read → `dout=8'hC6` next cycle. A0=1 read → `8'hFF`. After the read ends, `dout` holds its value.
- **Reset behaviour.**
  - Assert `reset` mid-busy with `wr_n` low → `busy=0`, `dout=0`, `addr_q=0` after reset.
  - No pulse on release until `wr_n` goes high then low again.

Source files
------------

// File: rtl/opl2_host_if_if.sv
// Shared types and the CPU-side bus bundle for the OPL2 host front end.

package opl2_host_if_pkg;

    // One register-file write: valid pulse plus target register and value.
    typedef struct packed {
        logic       valid;
        logic [7:0] address;
        logic [7:0] data;
    } opl2_reg_wr_t;

    // Register addresses at or above this value do not exist in a bank.
    localparam logic [7:0] NumRegPerBank = 8'hF6;

endpackage

// Two-port CPU bus: strobes, A0, write data, read data and the advisory busy flag.
interface opl2_host_if_if;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       address;
    logic [7:0] din;
    logic [7:0] dout;
    logic       busy;

    modport master (
        output cs_n,
        output wr_n,
        output rd_n,
        output address,
        output din,
        input  dout,
        input  busy
    );

    modport slave (
        input  cs_n,
        input  wr_n,
        input  rd_n,
        input  address,
        input  din,
        output dout,
        output busy
    );
endinterface

// File: rtl/opl2_host_if.sv
// OPL2 host register-write front end: decodes address/data port writes into
// single-cycle register-file writes, emulates the YM3812 post-write wait on
// busy, and returns the status byte on reads.

module opl2_host_if
    import opl2_host_if_pkg::*;
#(
    parameter int unsigned ADDR_WAIT_CYCLES = 235,
    parameter int unsigned DATA_WAIT_CYCLES = 1643
) (
    input  logic          clk,
    input  logic          reset,
    opl2_host_if_if.slave bus,
    input  logic          irq,
    input  logic          ft1,
    input  logic          ft2,
    output opl2_reg_wr_t  opl2_reg_wr
);

    localparam int unsigned CntW = $clog2(DATA_WAIT_CYCLES + 1);
    localparam logic [CntW-1:0] AddrWait = CntW'(ADDR_WAIT_CYCLES);
    localparam logic [CntW-1:0] DataWait = CntW'(DATA_WAIT_CYCLES);

    logic            wr_n_q;
    logic [7:0]      addr_q, addr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            busy_q;
    logic [7:0]      dout_q, dout_d;
    opl2_reg_wr_t    reg_wr_q, reg_wr_d;
    logic            wr_event;
    logic            rd_active;
    logic [7:0]      status;

    // Event only on the falling edge of wr_n while selected; wr_n_q resets low so
    // a strobe held through reset release must rise and fall again.
    assign wr_event  = ~bus.cs_n & ~bus.wr_n & wr_n_q;
    assign rd_active = ~bus.cs_n & ~bus.rd_n;
    assign status    = {irq, ft1, ft2, 5'b00110};

    // Next-state: address latch, register-write pulse, wait counter and read data.
    always_comb begin
        addr_d         = addr_q;
        reg_wr_d       = reg_wr_q;
        reg_wr_d.valid = 1'b0;
        count_d        = (count_q != '0) ? count_q - CntW'(1) : count_q;
        dout_d         = dout_q;

        if (wr_event) begin
            if (!bus.address) begin
                addr_d  = bus.din;
                count_d = AddrWait;
            end else begin
                // Reload rather than extend: a write while busy restarts the wait.
                count_d = DataWait;
                if (addr_q < NumRegPerBank) begin
                    reg_wr_d.valid   = 1'b1;
                    reg_wr_d.address = addr_q;
                    reg_wr_d.data    = bus.din;
                end
            end
        end

        if (rd_active) begin
            dout_d = bus.address ? 8'hFF : status;
        end
    end

    // State update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_n_q   <= 1'b0;
            addr_q   <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            dout_q   <= 8'h00;
            reg_wr_q <= '0;
        end else begin
            wr_n_q   <= bus.wr_n;
            addr_q   <= addr_d;
            count_q  <= count_d;
            // Registered from the next count so busy tracks count != 0 exactly.
            busy_q   <= (count_d != '0);
            dout_q   <= dout_d;
            reg_wr_q <= reg_wr_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.dout    = dout_q;
    assign opl2_reg_wr = reg_wr_q;

endmodule

// File: tb/tb_opl2_host_if.sv
// Self-checking bench for opl2_host_if: a time-based behavioural model checked
// every cycle, plus directed scenarios with literal expectations.

module tb_opl2_host_if;
    import opl2_host_if_pkg::*;

    logic         clk;
    logic         reset;
    logic         irq, ft1, ft2;
    opl2_reg_wr_t opl2_reg_wr;

    opl2_host_if_if bus ();

    opl2_host_if dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .irq         (irq),
        .ft1         (ft1),
        .ft2         (ft2),
        .opl2_reg_wr (opl2_reg_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: busy is a time window [event edge, event edge + W - 1].
    int         cyc      = 0;
    int         busy_end = -1;
    bit         m_live   = 0;
    bit         m_prev_wr_n;
    logic [7:0] m_addr;
    logic       m_valid;
    logic [7:0] m_paddr, m_pdata;
    logic [7:0] m_dout;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                m_live      = 1;
                m_prev_wr_n = 0;
                m_addr      = 8'h00;
                busy_end    = -1;
                m_valid     = 0;
                m_paddr     = 8'h00;
                m_pdata     = 8'h00;
                m_dout      = 8'h00;
            end else begin
                m_valid = 0;
                if (!bus.cs_n && !bus.rd_n)
                    m_dout = bus.address ? 8'hFF : {irq, ft1, ft2, 5'b00110};
                if (!bus.cs_n && !bus.wr_n && m_prev_wr_n) begin
                    if (!bus.address) begin
                        m_addr   = bus.din;
                        busy_end = cyc + 235 - 1;
                    end else begin
                        busy_end = cyc + 1643 - 1;
                        if (m_addr < 8'hF6) begin
                            m_valid = 1;
                            m_paddr = m_addr;
                            m_pdata = bus.din;
                        end
                    end
                end
                m_prev_wr_n = bus.wr_n;
            end
        end
    end

    // Per-cycle comparison against the model, plus pulse bookkeeping for directed checks.
    int           pulse_cnt  = 0;
    opl2_reg_wr_t last_pulse = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("busy",   32'(bus.busy),          32'(cyc <= busy_end));
                check("dout",   32'(bus.dout),          32'(m_dout));
                check("valid",  32'(opl2_reg_wr.valid), 32'(m_valid));
                check("waddr",  32'(opl2_reg_wr.address), 32'(m_paddr));
                check("wdata",  32'(opl2_reg_wr.data),  32'(m_pdata));
            end
            if (opl2_reg_wr.valid === 1'b1) begin
                pulse_cnt++;
                last_pulse = opl2_reg_wr;
            end
        end
    end

    task automatic do_write(input logic a, input logic [7:0] d);
        @(posedge clk); #1;
        bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.address = a; bus.din = d;
        @(posedge clk); #1;
        bus.cs_n = 1'b1; bus.wr_n = 1'b1;
    endtask

    // Counts busy-high cycles following the current point, bounded.
    task automatic measure_busy(output int n);
        n = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b1) break;
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int p0;

        reset = 1'b1;
        irq = 1'b0; ft1 = 1'b0; ft2 = 1'b0;
        bus.cs_n = 1'b1; bus.wr_n = 1'b1; bus.rd_n = 1'b1;
        bus.address = 1'b0; bus.din = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_dout",  32'(bus.dout), 32'h00);
        check("rst_reg_wr", 32'(opl2_reg_wr), 32'h0);

        // Basic write: address 0x20 then data 0x01.
        p0 = pulse_cnt;
        do_write(1'b0, 8'h20);
        do_write(1'b1, 8'h01);
        measure_busy(n);
        check("basic_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("basic_pulse",  32'(last_pulse), 32'h1_20_01);
        check("data_busy_len", 32'(n), 32'd1643);

        // Address-write busy length.
        do_write(1'b0, 8'h20);
        measure_busy(n);
        check("addr_busy_len", 32'(n), 32'd235);

        // Out-of-range register: no pulse, full data wait.
        p0 = pulse_cnt;
        do_write(1'b0, 8'hF6);
        do_write(1'b1, 8'h55);
        measure_busy(n);
        check("oor_pulses", 32'(pulse_cnt - p0), 32'd0);
        check("oor_busy_len", 32'(n), 32'd1643);
        do_write(1'b0, 8'hF5);
        do_write(1'b1, 8'h66);
        measure_busy(n);
        check("top_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("top_pulse",  32'(last_pulse), 32'h1_F5_66);

        // Reload: data write 100 cycles into an address wait.
        do_write(1'b0, 8'h10);
        repeat (100) @(posedge clk);
        do_write(1'b1, 8'h5A);
        measure_busy(n);
        check("reload_busy_len", 32'(n), 32'd1643);
        check("reload_pulse", 32'(last_pulse), 32'h1_10_5A);

        // wr_n held low for 50 cycles: one event only.
        p0 = pulse_cnt;
        @(posedge clk); #1;
        bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.address = 1'b1; bus.din = 8'h77;
        repeat (50) @(posedge clk);
        #1 bus.cs_n = 1'b1; bus.wr_n = 1'b1;
        measure_busy(n);
        check("hold_pulses", 32'(pulse_cnt - p0), 32'd1);
        check("hold_pulse",  32'(last_pulse), 32'h1_10_77);

        // Status read.
        irq = 1'b1; ft1 = 1'b1; ft2 = 1'b0;
        @(posedge clk); #1;
        bus.cs_n = 1'b0; bus.rd_n = 1'b0; bus.address = 1'b0;
        @(posedge clk); #1;
        bus.address = 1'b1;
        @(negedge clk);
        check("status_c6", 32'(bus.dout), 32'hC6);
        @(posedge clk); #1;
        bus.cs_n = 1'b1; bus.rd_n = 1'b1; irq = 1'b0;
        @(negedge clk);
        check("data_port_ff", 32'(bus.dout), 32'hFF);
        repeat (3) @(negedge clk);
        check("dout_hold", 32'(bus.dout), 32'hFF);

        // Reset mid-busy with wr_n low, after a simultaneous read+write.
        do_write(1'b0, 8'h40);
        p0 = pulse_cnt;
        @(posedge clk); #1;
        bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.rd_n = 1'b0; bus.address = 1'b1; bus.din = 8'h11;
        @(posedge clk); #1;
        bus.rd_n = 1'b1;
        @(negedge clk);
        check("rw_pulse", 32'(last_pulse), 32'h1_40_11);
        check("rw_dout",  32'(bus.dout), 32'hFF);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_dout", 32'(bus.dout), 32'h00);
        repeat (10) @(posedge clk);
        check("rst_no_pulse", 32'(pulse_cnt - p0), 32'd1);
        #1 bus.cs_n = 1'b1; bus.wr_n = 1'b1;
        do_write(1'b1, 8'h99);
        measure_busy(n);
        check("rst_addr_zero", 32'(last_pulse), 32'h1_00_99);
        check("rst_pulses", 32'(pulse_cnt - p0), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
